// File: rtl/ram_port_arbiter.sv
// Single-port RAM arbiter between the CPU memory path and the debug loader.
// Round-robin grant, registered strobes, RD_LATENCY read wait, one-cycle ack.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  output logic                  cpu_wait,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dbg_ack,
  input  logic                  dbg_lock,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  last_grant
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_t;

  localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY - 1);

  state_t r_state;
  state_t w_next;

  logic                  r_owner;
  logic                  r_last;
  logic [1:0]            r_cnt;
  logic                  r_ram_en;
  logic                  r_ram_we;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_wdata;
  logic [DATA_WIDTH-1:0] r_cpu_rdata;
  logic [DATA_WIDTH-1:0] r_dbg_rdata;

  logic w_cpu_elig;
  logic w_dbg_elig;
  logic w_grant;
  logic w_sel_dbg;

  assign w_cpu_elig = cpu_req & ~dbg_lock;
  assign w_dbg_elig = dbg_req;
  assign w_grant    = w_cpu_elig | w_dbg_elig;
  // On contention the side that did not win last time goes first
  assign w_sel_dbg  = w_dbg_elig & (~w_cpu_elig | ~r_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   if (w_grant) w_next = ACCESS;
      ACCESS: w_next = r_ram_we ? RESP : WAIT;
      WAIT:   if (r_cnt == 2'd0) w_next = RESP;
      RESP:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner     <= 1'b0;
      r_last      <= 1'b0;
      r_cnt       <= 2'd0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_owner     <= w_sel_dbg;
            r_last      <= w_sel_dbg;
            r_ram_en    <= 1'b1;
            r_ram_we    <= w_sel_dbg ? dbg_we : cpu_we;
            r_ram_addr  <= w_sel_dbg ? dbg_addr : cpu_addr;
            r_ram_wdata <= w_sel_dbg ? dbg_wdata : cpu_wdata;
          end
        end
        ACCESS: begin
          r_ram_en <= 1'b0;
          r_ram_we <= 1'b0;
          r_cnt    <= CNT_INIT;
        end
        WAIT: begin
          if (r_cnt == 2'd0) begin
            if (r_owner) r_dbg_rdata <= ram_rdata;
            else         r_cpu_rdata <= ram_rdata;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_ack    = (r_state == RESP) & ~r_owner;
  assign dbg_ack    = (r_state == RESP) & r_owner;
  assign cpu_wait   = cpu_req & ~cpu_ack;
  assign cpu_rdata  = r_cpu_rdata;
  assign dbg_rdata  = r_dbg_rdata;
  assign ram_en     = r_ram_en;
  assign ram_we     = r_ram_we;
  assign ram_addr   = r_ram_addr;
  assign ram_wdata  = r_ram_wdata;
  assign last_grant = r_last;

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port main RAM between two requesters: the CPU datapath memory interface (MAR/MDR Read/Write path) and the debug/program-loader port.
- Sequences every RAM access: grant, address/strobe issue, read-latency wait, response capture and acknowledge.
- Gives the control unit a wait signal so the present state holds while a CPU access is pending.
- Supports a debug lock that holds the CPU off the RAM during program load.

Parameters:
- ADDR_WIDTH, 9, RAM word-address width (512 words).
- DATA_WIDTH, 32, data word width.
- RD_LATENCY, 1, RAM cycles from registered read strobe to valid ram_rdata (legal range 1..4).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; level, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; sampled at grant.
- cpu_addr  in  ADDR_WIDTH  CPU word address (from MAR); sampled at grant.
- cpu_wdata  in  DATA_WIDTH  CPU write data (from MDR); sampled at grant.
- cpu_rdata  out  DATA_WIDTH  read data to MDR; valid while cpu_ack=1.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_wait  out  1  combinational: cpu_req & ~cpu_ack; stalls the control unit.
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  debug-port equivalents of the cpu_* inputs.
- dbg_rdata, dbg_ack  out  DATA_WIDTH/1  debug-port equivalents of cpu_rdata/cpu_ack.
- dbg_lock  in  1  while high, the CPU is never granted.
- ram_en, ram_we  out  1/1  registered RAM strobes.
- ram_addr  out  ADDR_WIDTH  registered RAM address.
- ram_wdata  out  DATA_WIDTH  registered RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM read data.
- last_grant  out  1  0 = CPU, 1 = debug; most recent grant.

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous, active-high.
- Reset values: state IDLE, wait counter 0, last_grant 0, every output strobe/ack 0, all data/address outputs 0.
- FSM states: IDLE, ACCESS, WAIT, RESP. Owner register holds CPU or DBG.
- IDLE, no eligible request: stay in IDLE.
  - CPU is eligible when cpu_req & ~dbg_lock.
  - Debug is eligible when dbg_req.
- IDLE, exactly one eligible: grant it.
- IDLE, both eligible: round-robin; grant the one not equal to last_grant.
- On grant:
  - Latch we, addr and wdata from the owner into ram_we/ram_addr/ram_wdata.
  - Set ram_en=1 and update last_grant.
  - Go to ACCESS.
- ACCESS (1 cycle): strobes valid for this cycle; ram_en and ram_we are cleared at its end.
  - Write: go to RESP.
  - Read: load counter with RD_LATENCY-1 and go to WAIT.
- WAIT: decrement the counter each cycle. At 0, capture ram_rdata into the owner's rdata register and go to RESP. With RD_LATENCY=1, WAIT lasts 1 cycle.
- RESP (1 cycle): owner's ack=1, then go to IDLE. The non-owner ack is always 0 here.
- rdata outputs hold their last captured value until the next read by the same owner.
- Timing, with req first sampled high in IDLE at cycle N:
  - ram_en high in cycle N+1.
  - Write: ack in cycle N+2.
  - Read: ack in cycle N+2+RD_LATENCY.
- Requester rules:
  - The requester must drop req in the cycle after ack; IDLE re-samples in that cycle.
  - A req still high then starts a new transaction.
  - Minimum request-to-request spacing is therefore 3 cycles (write) or 3+RD_LATENCY cycles (read).
- Input changes after grant (addr/we/wdata/req) are ignored until RESP.
- Dropping req mid-transaction does not abort it: the access completes and ack still pulses.
- dbg_lock:
  - Evaluated only in IDLE; it never aborts an in-flight CPU transaction.
  - While locked, cpu_wait stays high for a pending cpu_req.
- Reset asserted in any state: FSM returns to IDLE at that edge and no ack is produced.
  - A write whose ACCESS cycle coincides with the reset edge may be committed by the RAM.
  - Requesters must re-issue after reset.
- Address arithmetic: none; the address passes through unchanged, with no wrap handling. ADDR_WIDTH bits are used as given.

Test Plan:
- Reset, then CPU write addr 0x05 data 0xDEADBEEF at cycle N → ram_en=ram_we=1, ram_addr=0x05 in N+1; cpu_ack in N+2; cpu_wait low from N+2.
- CPU read addr 0x05, RD_LATENCY=1 → ram_en=1, ram_we=0 in N+1; cpu_ack in N+3 with cpu_rdata=0xDEADBEEF; dbg_ack stays 0.
- cpu_req and dbg_req rise in the same cycle with last_grant=0 → debug served first, CPU granted on the IDLE cycle after dbg_ack. Repeat 4 times → grants alternate D,C,D,C.
- dbg_lock=1 while the debug port loads 0x00..0x03 with 0x11,0x22,0x33,0x44 and cpu_req held high → no CPU grant, cpu_wait high throughout. Lock dropped → CPU read of 0x02 returns 0x33.
- Reset asserted during WAIT of a CPU read → next cycle state IDLE, all outputs 0, no cpu_ack; a re-issued read completes normally.
- RD_LATENCY=3 build: debug read → dbg_ack exactly 5 cycles after dbg_req first sampled, with data equal to the RAM word.
